// File: rtl/dcache_wt_responder.sv
// dcache_wt_responder: direct-mapped, one-word-per-line, write-through,
// no-write-allocate data cache sitting between the CPU memory stage and a
// single-word physical-memory port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   data_read/data_write     CPU request strobes, held until data_resp
//   data_mbe/addr/wdata      CPU byte enables, byte address, aligned write data
//   data_resp/data_rdata     one-cycle completion pulse and read word
//   pmem_read/pmem_write     memory request strobes, held until pmem_resp
//   pmem_mbe/addr/wdata      memory byte enables, word address, write data
//   pmem_resp/pmem_rdata     memory completion pulse and read word
//
// Optional feature macro: DCACHE_PERF_EN adds perf_hits/perf_misses counters.
module dcache_wt_responder #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_resp,
  output logic [31:0] data_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_mbe,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int unsigned LINES = 1 << IDX_BITS;
  localparam int unsigned TAG_W = 30 - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      data_rdata_q, data_rdata_d;
  logic             rdata_we;

  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [31:0]         merged_word;
  logic                line_we;
  logic [31:0]         line_wdata;
  logic                unused_addr_lsb;

  // Address decode; the byte offset plays no part in the lookup.
  assign idx             = data_addr[IDX_BITS+1:2];
  assign tag             = data_addr[31:IDX_BITS+2];
  assign unused_addr_lsb = ^data_addr[1:0];
  assign hit             = valid_q[idx] && (tag_q[idx] == tag);

  // Byte-enable merge of CPU write data into the cached word.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged_word[8*b +: 8] = data_mbe[b] ? data_wdata[8*b +: 8]
                                          : data_q[idx][8*b +: 8];
    end
  end

  // Moore strobes decoded from the state register only.
  assign data_resp  = (state_q == RESP);
  assign pmem_read  = (state_q == FILL);
  assign pmem_write = (state_q == WRITE);
  assign data_rdata = data_rdata_q;

  // Memory request payload follows the CPU inputs, which are held stable.
  assign pmem_addr  = {data_addr[31:2], 2'b00};
  assign pmem_wdata = data_wdata;
  assign pmem_mbe   = (state_q == WRITE) ? data_mbe : 4'hF;

  // Next-state and array update decode.
  always_comb begin
    state_d      = state_q;
    line_we      = 1'b0;
    line_wdata   = data_q[idx];
    rdata_we     = 1'b0;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        // A simultaneous read and write is serviced as a write.
        if (data_write) begin
          state_d = WRITE;
        end else if (data_read) begin
          if (hit) begin
            state_d      = RESP;
            rdata_we     = 1'b1;
            data_rdata_d = data_q[idx];
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (pmem_resp) begin
          line_we      = 1'b1;
          line_wdata   = pmem_rdata;
          rdata_we     = 1'b1;
          data_rdata_d = pmem_rdata;
          state_d      = RESP;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          // Write-through with no allocate: only an already-present line is updated.
          if (hit) begin
            line_we    = 1'b1;
            line_wdata = merged_word;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, valid bits and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (line_we) begin
        valid_q[idx] <= 1'b1;
      end
      if (rdata_we) begin
        data_rdata_q <= data_rdata_d;
      end
    end
  end

  // Tag and data arrays need no reset; the valid vector qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_wdata;
    end
  end

`ifdef DCACHE_PERF_EN
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] perf_hits_q;
  logic [31:0] perf_misses_q;

  // Events mirror the IDLE->RESP (read hit) and IDLE->FILL transitions.
  assign hit_evt  = (state_q == IDLE) && !data_write && data_read && hit;
  assign miss_evt = (state_q == IDLE) && !data_write && data_read && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      if (hit_evt) begin
        perf_hits_q <= perf_hits_q + 32'd1;
      end
      if (miss_evt) begin
        perf_misses_q <= perf_misses_q + 32'd1;
      end
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_dcache_wt_responder.sv
// Directed bench for dcache_wt_responder with a hand-driven memory model.
module tb_dcache_wt_responder;

  logic        clk;
  logic        rst;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_mbe;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif

  int checks = 0;
  int errors = 0;

  // Results of the last transaction.
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [3:0]  r_mbe;
  logic [31:0] r_wdata;
  int          r_reads;
  int          r_writes;
  int          r_lat;
  int          r_gap;
  logic        r_got;

  dcache_wt_responder #(.IDX_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_read  (data_read),
    .data_write (data_write),
    .data_mbe   (data_mbe),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_resp  (data_resp),
    .data_rdata (data_rdata),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_mbe   (pmem_mbe),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_resp  (pmem_resp),
    .pmem_rdata (pmem_rdata)
`ifdef DCACHE_PERF_EN
    ,
    .perf_hits  (perf_hits),
    .perf_misses(perf_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; the memory answers after 'delay' cycles of request.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mbe,
                     input int delay, input logic [31:0] mrdata);
    int   wait_cnt;
    int   resp_cyc;
    logic prev_active;
    r_reads = 0; r_writes = 0; r_lat = -1; r_gap = -1; r_got = 1'b0;
    r_addr = 'x; r_mbe = 'x; r_wdata = 'x; r_rdata = 'x;
    wait_cnt = 0; resp_cyc = -1; prev_active = 1'b0;
    data_read = rd; data_write = wr; data_addr = addr;
    data_wdata = wdata; data_mbe = mbe;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      tick();
      pmem_resp = 1'b0;
      if (data_resp) begin
        r_got   = 1'b1;
        r_rdata = data_rdata;
        r_lat   = cyc;
        if (resp_cyc >= 0) r_gap = cyc - resp_cyc;
        break;
      end
      if (pmem_read || pmem_write) begin
        if (!prev_active) begin
          if (pmem_read)  r_reads++;
          if (pmem_write) r_writes++;
          r_addr  = pmem_addr;
          r_mbe   = pmem_mbe;
          r_wdata = pmem_wdata;
        end
        wait_cnt++;
        if (wait_cnt == delay) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mrdata;
          wait_cnt   = 0;
          resp_cyc   = cyc;
        end
      end
      prev_active = pmem_read || pmem_write;
    end
    chk("resp_seen", 32'(r_got), 32'd1);
    data_read = 1'b0; data_write = 1'b0;
    tick();
    chk("resp_one_cycle", 32'(data_resp), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
    data_addr = '0; data_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;

    // Reset state.
    do_reset();
    chk("rst_data_resp",  32'(data_resp),  32'd0);
    chk("rst_pmem_read",  32'(pmem_read),  32'd0);
    chk("rst_pmem_write", 32'(pmem_write), 32'd0);
    chk("rst_data_rdata", data_rdata,      32'h0);
`ifdef DCACHE_PERF_EN
    chk("rst_perf_hits",   perf_hits,   32'd0);
    chk("rst_perf_misses", perf_misses, 32'd0);
`endif

    // Cold read miss, memory replies after 3 cycles.
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 3, 32'hDEAD_BEEF);
    chk("miss_rdata",   r_rdata,         32'hDEAD_BEEF);
    chk("miss_reads",   32'(r_reads),    32'd1);
    chk("miss_writes",  32'(r_writes),   32'd0);
    chk("miss_addr",    r_addr,          32'h0000_0040);
    chk("miss_mbe",     32'(r_mbe),      32'hF);
    chk("miss_lat",     32'(r_lat),      32'd4);
    chk("miss_gap",     32'(r_gap),      32'd1);

    // Read hit: one-cycle latency, no memory traffic.
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h0BAD_0BAD);
    chk("hit_rdata", r_rdata,      32'hDEAD_BEEF);
    chk("hit_reads", 32'(r_reads), 32'd0);
    chk("hit_lat",   32'(r_lat),   32'd1);

    // Partial write hit, write-through with byte enables.
    txn(1'b0, 1'b1, 32'h0000_0040, 32'h0000_1234, 4'b0011, 2, 32'h0);
    chk("wr_writes", 32'(r_writes), 32'd1);
    chk("wr_reads",  32'(r_reads),  32'd0);
    chk("wr_mbe",    32'(r_mbe),    32'h3);
    chk("wr_addr",   r_addr,        32'h0000_0040);
    chk("wr_wdata",  r_wdata,       32'h0000_1234);
    chk("wr_lat",    32'(r_lat),    32'd3);
    chk("wr_gap",    32'(r_gap),    32'd1);

    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h0BAD_0BAD);
    chk("merge_rdata", r_rdata,      32'hDEAD_1234);
    chk("merge_reads", 32'(r_reads), 32'd0);

    // Write miss does not allocate.
    txn(1'b0, 1'b1, 32'h0000_0082, 32'hCAFE_F00D, 4'hF, 1, 32'h0);
    chk("wmiss_writes", 32'(r_writes), 32'd1);
    chk("wmiss_addr",   r_addr,        32'h0000_0080);
    txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1, 32'h1111_2222);
    chk("noalloc_reads", 32'(r_reads), 32'd1);
    chk("noalloc_rdata", r_rdata,      32'h1111_2222);

    // Conflict misses on one index from a cold cache.
    do_reset();
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hA1A1_A1A1);
    chk("conf1_reads", 32'(r_reads), 32'd1);
    txn(1'b1, 1'b0, 32'h0000_0440, 32'h0, 4'h0, 2, 32'hA2A2_A2A2);
    chk("conf2_reads", 32'(r_reads), 32'd1);
    chk("conf2_rdata", r_rdata,      32'hA2A2_A2A2);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hA3A3_A3A3);
    chk("conf3_reads", 32'(r_reads), 32'd1);
    chk("conf3_rdata", r_rdata,      32'hA3A3_A3A3);
`ifdef DCACHE_PERF_EN
    chk("conf_perf_misses", perf_misses, 32'd3);
    chk("conf_perf_hits",   perf_hits,   32'd0);
`endif

    // Read and write together behave as a write.
    txn(1'b1, 1'b1, 32'h0000_0040, 32'h7700_0000, 4'b1000, 1, 32'h0);
    chk("rw_writes", 32'(r_writes), 32'd1);
    chk("rw_reads",  32'(r_reads),  32'd0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h0);
    chk("rw_rdata",  r_rdata,       32'h77A3_A3A3);
    chk("rw_lat",    32'(r_lat),    32'd1);
`ifdef DCACHE_PERF_EN
    chk("rw_perf_hits",   perf_hits,   32'd1);
    chk("rw_perf_misses", perf_misses, 32'd3);
`endif

    // Reset during a fill, late memory response ignored.
    do_reset();
    data_read = 1'b1; data_addr = 32'h0000_0040;
    tick();
    chk("abort_in_fill", 32'(pmem_read), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; data_read = 1'b0;
    chk("abort_pmem_read", 32'(pmem_read), 32'd0);
    pmem_resp = 1'b1; pmem_rdata = 32'h5555_5555;
    tick();
    pmem_resp = 1'b0;
    chk("abort_no_resp",  32'(data_resp), 32'd0);
    chk("abort_idle",     32'(pmem_read || pmem_write), 32'd0);
    tick();
    chk("abort_no_resp2", 32'(data_resp), 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 2, 32'h1357_9BDF);
    chk("abort_remiss", 32'(r_reads), 32'd1);
    chk("abort_rdata",  r_rdata,      32'h1357_9BDF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
